output_port_buffer: RTL
=======================

# output_port_buffer

Downstream consumer of the processor's OUT instruction. Captures each 16-bit value the processor writes to its output port into a small first-in-first-out queue and drains the queue to an external device over a valid/ready handshake. Keeps a mirror of the most recently accepted value for the board-level `outputPort` pins. Raises `full` so the processor stalls its write-back instead of losing data.

## Interface
- `WIDTH`, 16, data width of port values
- `DEPTH`, 4, queue entries; power of two, ≥2
- `PTR_W`, 2, log2(`DEPTH`)

- `clk`  in  1  single clock, all state updates on the rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `outWrite`  in  1  processor OUT strobe, one write per high cycle
- `outData`  in  `WIDTH`  value written by OUT
- `full`  out  1  queue cannot accept a write this cycle
- `devValid`  out  1  head entry available to the device
- `devData`  out  `WIDTH`  head entry
- `devReady`  in  1  device accepts the head entry this cycle
- `outputPort`  out  `WIDTH`  last accepted value (pin mirror)
- `count`  out  `PTR_W`+1  occupied entries, 0..`DEPTH`
- `overflow`  out  1  sticky: a write was dropped
- `clrOverflow`  in  1  synchronous clear of `overflow`

## Operation
- Storage: `DEPTH`×`WIDTH` register array.
  - Write pointer and read pointer are `PTR_W` bits each and wrap modulo `DEPTH`.
  - `count` is tracked separately to distinguish full from empty.
- Pop: `devValid && devReady`.
  - Read pointer advances; `count` decrements.
- Push: `outWrite && (!full || pop)`.
  - Data is stored at the write pointer; write pointer advances.
  - `outputPort` ← `outData`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - This is legal when full: the slot freed by the pop is reused.
- Dropped write: `outWrite && full && !pop`.
  - Data is discarded; no pointer moves; `overflow` ← 1.
- `overflow` clear rules:
  - Cleared only by `clrOverflow` or reset.
  - If `clrOverflow` and a dropped write occur in the same cycle, set wins and `overflow` = 1.
- Combinational outputs:
  - `full` = (`count` == `DEPTH`)
  - `devValid` = (`count` != 0)
  - `devData` = array[read pointer], first-word-fall-through
- `devReady` while `devValid` = 0 has no effect.
- Pop while empty never occurs. Simultaneous push into an empty queue does not bypass to the device in the same cycle.
- Reset, asynchronous on `resetN` low, including mid-transfer:
  - Pointers, `count`, `overflow` and `outputPort` are 0.
  - `full` = 0, `devValid` = 0, `devData` is don't-care (array not cleared).
  - Queued data is lost.
  - On `resetN` release, the first rising edge operates normally.

## Timing
- Write-to-device latency is 1 cycle. A push at edge N gives `devValid` = 1 and `devData` = value during the cycle after N.
- `outputPort` updates at the push edge and holds until the next push.
- The device must sample `devData` in the cycle `devReady` is high. The next entry appears after that edge.
- `full` reflects the current state. The processor must treat `full` && !`devReady` as a stall of the OUT write-back.
- Sustained throughput is one push and one pop per cycle.

## Test plan
- Reset then idle:
  - `resetN` = 0 for 2 cycles, then 1, no writes.
  - Expect `count` = 0, `devValid` = 0, `full` = 0, `overflow` = 0, `outputPort` = 0x0000.
- Single transfer:
  - Write 0x1234 with `devReady` = 0.
  - Next cycle: `devValid` = 1, `devData` = 0x1234, `outputPort` = 0x1234, `count` = 1.
  - Assert `devReady` for 1 cycle; then `count` = 0, `devValid` = 0.
- Fill and order:
  - `devReady` = 0; write 0x0001..0x0004 on consecutive cycles.
  - Expect `full` = 1, `count` = 4.
  - Then `devReady` = 1: device receives 0x0001, 0x0002, 0x0003, 0x0004 in order, then `devValid` = 0.
- Overflow:
  - With the queue full and `devReady` = 0, write 0xDEAD.
  - Expect `overflow` = 1, `count` = 4, `outputPort` = 0x0004, and 0xDEAD never reaches `devData`.
  - Pulse `clrOverflow`; expect `overflow` = 0.
- Full with simultaneous push/pop:
  - Queue full with 0xA0..0xA3; `devReady` = 1 and write 0xB0 in the same cycle.
  - Expect `count` = 4, `overflow` = 0.
  - Drain order: 0xA1, 0xA2, 0xA3, 0xB0 (pointer wrap exercised).
- Reset mid-operation:
  - With 3 entries queued and `devReady` toggling, drop `resetN` between clock edges.
  - Outputs go to reset values immediately, without waiting for an edge.
  - After release, write 0x00FF; the device receives only 0x00FF.

Source files
------------

// File: rtl/output_port_buffer.sv
// Output port buffer: queues values written by the OUT instruction and
// drains them to an external device over a valid/ready handshake.
//
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   outWrite, outData         processor OUT strobe and value
//   full                      queue cannot take a write this cycle
//   devValid, devData         head entry offered to the device (FWFT)
//   devReady                  device takes the head entry this cycle
//   outputPort                mirror of the last accepted value
//   count                     occupied entries, 0..DEPTH
//   overflow, clrOverflow     sticky dropped-write flag and its clear
module output_port_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             outWrite,
    input  logic [WIDTH-1:0] outData,
    output logic             full,
    output logic             devValid,
    output logic [WIDTH-1:0] devData,
    input  logic             devReady,
    output logic [WIDTH-1:0] outputPort,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    input  logic             clrOverflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   cnt;
    logic             pop;
    logic             push;
    logic             drop;

    assign full     = (cnt == FULL_CNT);
    assign devValid = (cnt != '0);
    assign devData  = mem[rdPtr];
    assign count    = cnt;

    assign pop  = devValid && devReady;
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    assign push = outWrite && (!full || pop);
    assign drop = outWrite && full && !pop;

    // Storage is never cleared; contents behind devValid=0 are don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= outData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            cnt        <= '0;
            outputPort <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wrPtr      <= wrPtr + PTR_ONE;
                outputPort <= outData;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clrOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
